// File: rtl/dpd_coeff_bank_368.sv
// Double-buffered a10/a30/a50 coefficient bank. The shadow set is swapped into the active set atomically on frame_sync.
// Optional DPD_COEFF_READBACK_EN adds a registered read port (rd_addr/rd_data) onto the active bank.
module dpd_coeff_bank_368 #(
  parameter int INT_WIDTH    = 4,
  parameter int FRACT_WIDTH  = 12,
  parameter int DATA_WIDTH   = INT_WIDTH + FRACT_WIDTH,
  parameter int SYNC_TIMEOUT = 1024
) (
  input  logic                         clk_368,
  input  logic                         rst_n,
  input  logic                         wr_valid,
  output logic                         wr_ready,
  input  logic [2:0]                   wr_addr,
  input  logic [DATA_WIDTH-1:0]        wr_data,
  input  logic                         commit_req,
  input  logic                         frame_sync,
  output logic                         commit_ack,
  output logic                         commit_nack,
  output logic                         addr_err,
  output logic [7:0]                   swap_count,
  output logic signed [DATA_WIDTH-1:0] a10_r,
  output logic signed [DATA_WIDTH-1:0] a10_i,
  output logic signed [DATA_WIDTH-1:0] a30_r,
  output logic signed [DATA_WIDTH-1:0] a30_i,
  output logic signed [DATA_WIDTH-1:0] a50_r,
  output logic signed [DATA_WIDTH-1:0] a50_i
`ifdef DPD_COEFF_READBACK_EN
  ,
  input  logic [2:0]                   rd_addr,
  output logic [DATA_WIDTH-1:0]        rd_data
`endif
);

  localparam int CW = (SYNC_TIMEOUT > 2) ? $clog2(SYNC_TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SYNC_TIMEOUT - 1);
  localparam logic [DATA_WIDTH-1:0] IDENTITY = DATA_WIDTH'(1) << FRACT_WIDTH;

  typedef enum logic {IDLE, PEND} state_e;

  state_e                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   shadow_q [6];
  logic [DATA_WIDTH-1:0]   active_q [6];
  logic [5:0]              dirty_q;
  logic                    addr_err_q;
  logic [7:0]              swap_count_q;
  logic                    ack_q, ack_d;
  logic                    nack_q, nack_d;

  logic                    wr_fire;
  logic                    wr_illegal;
  logic [5:0]              wr_mask;
  logic [5:0]              dirty_w;
  logic                    all_dirty;
  logic                    timeout;
  logic                    swap;

  // A write landing in the same cycle as commit_req counts toward completeness.
  always_comb begin
    wr_mask = '0;
    for (int i = 0; i < 6; i++) begin
      wr_mask[i] = wr_fire && (wr_addr == 3'(i));
    end
  end

  assign wr_fire    = wr_valid && (state_q == IDLE);
  assign wr_illegal = wr_fire && (wr_addr > 3'd5);
  assign dirty_w    = dirty_q | wr_mask;
  assign all_dirty  = &dirty_w;
  assign timeout    = (cnt_q == CNT_LAST);

  always_ff @(posedge clk_368 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (commit_req && all_dirty) state_d = PEND;
      PEND:    if (frame_sync || timeout) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // frame_sync wins over a timeout falling on the same cycle.
  always_comb begin
    wr_ready = (state_q == IDLE);
    swap     = (state_q == PEND) && frame_sync;
    ack_d    = swap;
    nack_d   = ((state_q == IDLE) && commit_req && !all_dirty) ||
               ((state_q == PEND) && !frame_sync && timeout);
    cnt_d    = (state_q == PEND) ? cnt_q + CW'(1) : '0;
  end

  always_ff @(posedge clk_368 or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 6; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
      shadow_q[0]  <= IDENTITY;
      active_q[0]  <= IDENTITY;
      dirty_q      <= '0;
      addr_err_q   <= 1'b0;
      swap_count_q <= '0;
      ack_q        <= 1'b0;
      nack_q       <= 1'b0;
      cnt_q        <= '0;
    end else begin
      ack_q  <= ack_d;
      nack_q <= nack_d;
      cnt_q  <= cnt_d;
      for (int i = 0; i < 6; i++) begin
        if (wr_mask[i]) shadow_q[i] <= wr_data;
      end
      if (swap) begin
        for (int i = 0; i < 6; i++) begin
          active_q[i] <= shadow_q[i];
        end
        dirty_q      <= '0;
        addr_err_q   <= 1'b0;
        swap_count_q <= swap_count_q + 8'd1;
      end else begin
        dirty_q <= dirty_w;
        if (wr_illegal) addr_err_q <= 1'b1;
      end
    end
  end

`ifdef DPD_COEFF_READBACK_EN
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

  always_comb begin
    rd_data_d = '0;
    for (int i = 0; i < 6; i++) begin
      if (rd_addr == 3'(i)) rd_data_d = active_q[i];
    end
  end

  always_ff @(posedge clk_368 or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;
`endif

  assign commit_ack  = ack_q;
  assign commit_nack = nack_q;
  assign addr_err    = addr_err_q;
  assign swap_count  = swap_count_q;
  assign a10_r       = active_q[0];
  assign a10_i       = active_q[1];
  assign a30_r       = active_q[2];
  assign a30_i       = active_q[3];
  assign a50_r       = active_q[4];
  assign a50_i       = active_q[5];

endmodule

// File: tb/tb_dpd_coeff_bank_368.sv
// Self-checking bench for dpd_coeff_bank_368: directed scenarios plus a randomized
// write/commit loop, all checked against a transaction-level model of the bank.
module tb_dpd_coeff_bank_368;

  localparam int DW = 16;
  localparam int TO = 64;

  logic clk_368 = 1'b0;
  logic rst_n = 1'b0;
  logic wr_valid = 1'b0;
  logic wr_ready;
  logic [2:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic commit_req = 1'b0;
  logic frame_sync = 1'b0;
  logic commit_ack, commit_nack, addr_err;
  logic [7:0] swap_count;
  logic signed [DW-1:0] a10_r, a10_i, a30_r, a30_i, a50_r, a50_i;
`ifdef DPD_COEFF_READBACK_EN
  logic [2:0] rd_addr = '0;
  logic [DW-1:0] rd_data;
`endif

  int checks = 0;
  int failures = 0;

  // Transaction-level model: shadow/active sets, completeness flags, error flag, swap tally.
  logic [DW-1:0] m_shadow [6];
  logic [DW-1:0] m_active [6];
  bit m_dirty [6];
  bit m_err;
  int m_swaps;

  dpd_coeff_bank_368 #(.SYNC_TIMEOUT(TO)) dut (
    .clk_368(clk_368), .rst_n(rst_n),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .commit_req(commit_req), .frame_sync(frame_sync),
    .commit_ack(commit_ack), .commit_nack(commit_nack),
    .addr_err(addr_err), .swap_count(swap_count),
    .a10_r(a10_r), .a10_i(a10_i), .a30_r(a30_r), .a30_i(a30_i),
    .a50_r(a50_r), .a50_i(a50_i)
`ifdef DPD_COEFF_READBACK_EN
    , .rd_addr(rd_addr), .rd_data(rd_data)
`endif
  );

  always #5 clk_368 = ~clk_368;

  function automatic logic [6*DW-1:0] dut_bank();
    return {a10_r, a10_i, a30_r, a30_i, a50_r, a50_i};
  endfunction

  function automatic logic [6*DW-1:0] model_bank();
    return {m_active[0], m_active[1], m_active[2], m_active[3], m_active[4], m_active[5]};
  endfunction

  function automatic bit model_complete();
    for (int i = 0; i < 6; i++) if (!m_dirty[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic tick();
    @(posedge clk_368);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 6; i++) begin
      m_shadow[i] = '0;
      m_active[i] = '0;
      m_dirty[i] = 1'b0;
    end
    m_shadow[0] = 16'd4096;
    m_active[0] = 16'd4096;
    m_err = 1'b0;
    m_swaps = 0;
  endtask

  task automatic model_swap();
    for (int i = 0; i < 6; i++) begin
      m_active[i] = m_shadow[i];
      m_dirty[i] = 1'b0;
    end
    m_err = 1'b0;
    m_swaps = (m_swaps + 1) % 256;
  endtask

  task automatic do_write(input logic [2:0] a, input logic [DW-1:0] d);
    wr_valid = 1'b1;
    wr_addr = a;
    wr_data = d;
    tick();
    wr_valid = 1'b0;
    if (a < 3'd6) begin
      m_shadow[a] = d;
      m_dirty[a] = 1'b1;
    end else begin
      m_err = 1'b1;
    end
  endtask

  task automatic do_commit();
    commit_req = 1'b1;
    tick();
    commit_req = 1'b0;
  endtask

  task automatic do_frame();
    frame_sync = 1'b1;
    tick();
    frame_sync = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (dut_bank() !== model_bank()) begin
      failures++;
      $display("[TB] FAIL reset_bank got=%h want=%h", dut_bank(), model_bank());
    end
    checks++;
    if ({wr_ready, swap_count, addr_err, commit_ack, commit_nack} !== {1'b1, 8'd0, 3'b000}) begin
      failures++;
      $display("[TB] FAIL reset_ctrl got rdy=%b cnt=%0d err=%b ack=%b nack=%b want 1/0/0/0/0",
               wr_ready, swap_count, addr_err, commit_ack, commit_nack);
    end
  endtask

  task automatic test_directed_swap();
    logic [DW-1:0] vals [6];
    vals = '{16'h1000, 16'h0010, 16'hFF00, 16'h0020, 16'h0008, 16'hFFF8};
    for (int i = 0; i < 6; i++) do_write(3'(i), vals[i]);
    do_commit();
    checks++;
    if (wr_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL pend_ready got=%b want=0", wr_ready);
    end
    repeat (4) tick();
    checks++;
    if (dut_bank() !== model_bank() || commit_ack !== 1'b0) begin
      failures++;
      $display("[TB] FAIL pend_hold got=%h ack=%b want=%h ack=0", dut_bank(), commit_ack, model_bank());
    end
    do_frame();
    model_swap();
    checks++;
    if (dut_bank() !== {vals[0], vals[1], vals[2], vals[3], vals[4], vals[5]}) begin
      failures++;
      $display("[TB] FAIL directed_bank got=%h want=%h", dut_bank(), model_bank());
    end
    checks++;
    if ({commit_ack, wr_ready, swap_count} !== {1'b1, 1'b1, 8'd1}) begin
      failures++;
      $display("[TB] FAIL directed_ack got ack=%b rdy=%b cnt=%0d want 1/1/1", commit_ack, wr_ready, swap_count);
    end
    tick();
    checks++;
    if (commit_ack !== 1'b0) begin
      failures++;
      $display("[TB] FAIL ack_pulse got=%b want=0", commit_ack);
    end
  endtask

  task automatic test_incomplete();
    for (int i = 0; i < 5; i++) do_write(3'(i), DW'($urandom));
    do_commit();
    checks++;
    if ({commit_nack, wr_ready} !== 2'b11 || dut_bank() !== model_bank()) begin
      failures++;
      $display("[TB] FAIL incomplete_nack got nack=%b rdy=%b bank=%h want 1/1 bank=%h",
               commit_nack, wr_ready, dut_bank(), model_bank());
    end
    tick();
    checks++;
    if (commit_nack !== 1'b0) begin
      failures++;
      $display("[TB] FAIL nack_pulse got=%b want=0", commit_nack);
    end
    do_write(3'd5, DW'($urandom));
    do_commit();
    tick();
    do_frame();
    model_swap();
    checks++;
    if (dut_bank() !== model_bank() || commit_ack !== 1'b1 || swap_count !== 8'(m_swaps)) begin
      failures++;
      $display("[TB] FAIL incomplete_retry got=%h ack=%b cnt=%0d want=%h ack=1 cnt=%0d",
               dut_bank(), commit_ack, swap_count, model_bank(), m_swaps);
    end
  endtask

  task automatic test_addr_err();
    for (int i = 0; i < 6; i++) do_write(3'(i), DW'($urandom));
    do_write(3'd7, 16'hDEAD);
    do_write(3'd6, 16'hBEEF);
    checks++;
    if (addr_err !== 1'b1) begin
      failures++;
      $display("[TB] FAIL addr_err_set got=%b want=1", addr_err);
    end
    do_commit();
    do_frame();
    model_swap();
    checks++;
    if (dut_bank() !== model_bank() || addr_err !== 1'b0) begin
      failures++;
      $display("[TB] FAIL addr_err_clear got bank=%h err=%b want bank=%h err=0", dut_bank(), addr_err, model_bank());
    end
  endtask

  task automatic test_timeout();
    int cycles;
    for (int i = 0; i < 6; i++) do_write(3'(i), DW'($urandom));
    do_commit();
    cycles = 0;
    while (commit_nack !== 1'b1 && cycles < TO + 10) begin
      tick();
      cycles++;
    end
    checks++;
    if (cycles !== TO) begin
      failures++;
      $display("[TB] FAIL timeout_latency got=%0d want=%0d", cycles, TO);
    end
    checks++;
    if (wr_ready !== 1'b1 || dut_bank() !== model_bank() || commit_ack !== 1'b0) begin
      failures++;
      $display("[TB] FAIL timeout_state got rdy=%b bank=%h ack=%b want rdy=1 bank=%h ack=0",
               wr_ready, dut_bank(), commit_ack, model_bank());
    end
    do_commit();
    repeat ($urandom_range(0, 4)) tick();
    do_frame();
    model_swap();
    checks++;
    if (dut_bank() !== model_bank() || commit_ack !== 1'b1) begin
      failures++;
      $display("[TB] FAIL timeout_retry got=%h ack=%b want=%h ack=1", dut_bank(), commit_ack, model_bank());
    end
  endtask

  task automatic test_same_cycle();
    for (int i = 0; i < 5; i++) do_write(3'(i), DW'($urandom));
    wr_data = DW'($urandom);
    m_shadow[5] = wr_data;
    m_dirty[5] = 1'b1;
    wr_valid = 1'b1;
    wr_addr = 3'd5;
    commit_req = 1'b1;
    frame_sync = 1'b1;
    tick();
    wr_valid = 1'b0;
    commit_req = 1'b0;
    frame_sync = 1'b0;
    checks++;
    if ({wr_ready, commit_nack} !== 2'b00) begin
      failures++;
      $display("[TB] FAIL same_cycle_pend got rdy=%b nack=%b want 0/0", wr_ready, commit_nack);
    end
    tick();
    checks++;
    if (commit_ack !== 1'b0 || dut_bank() !== model_bank()) begin
      failures++;
      $display("[TB] FAIL early_frame_ignored got ack=%b bank=%h want ack=0 bank=%h", commit_ack, dut_bank(), model_bank());
    end
    do_commit();
    do_frame();
    model_swap();
    checks++;
    if (dut_bank() !== model_bank() || commit_ack !== 1'b1 || swap_count !== 8'(m_swaps)) begin
      failures++;
      $display("[TB] FAIL same_cycle_swap got=%h ack=%b cnt=%0d want=%h ack=1 cnt=%0d",
               dut_bank(), commit_ack, swap_count, model_bank(), m_swaps);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 40; it++) begin
      if (it % 3 == 0) for (int i = 0; i < 6; i++) do_write(3'(i), DW'($urandom));
      repeat ($urandom_range(0, 6)) do_write(3'($urandom_range(0, 7)), DW'($urandom));
      if (model_complete()) begin
        do_commit();
        repeat ($urandom_range(0, 5)) tick();
        do_frame();
        model_swap();
        checks++;
        if (commit_ack !== 1'b1 || dut_bank() !== model_bank()) begin
          failures++;
          $display("[TB] FAIL rand_swap it=%0d got ack=%b bank=%h want ack=1 bank=%h", it, commit_ack, dut_bank(), model_bank());
        end
      end else begin
        do_commit();
        checks++;
        if (commit_nack !== 1'b1 || dut_bank() !== model_bank()) begin
          failures++;
          $display("[TB] FAIL rand_nack it=%0d got nack=%b bank=%h want nack=1 bank=%h", it, commit_nack, dut_bank(), model_bank());
        end
      end
      checks++;
      if (swap_count !== 8'(m_swaps) || addr_err !== m_err) begin
        failures++;
        $display("[TB] FAIL rand_status it=%0d got cnt=%0d err=%b want cnt=%0d err=%b", it, swap_count, addr_err, m_swaps, m_err);
      end
`ifdef DPD_COEFF_READBACK_EN
      rd_addr = 3'($urandom_range(0, 7));
      tick();
      checks++;
      if (rd_data !== ((rd_addr < 3'd6) ? m_active[rd_addr] : 16'd0)) begin
        failures++;
        $display("[TB] FAIL readback addr=%0d got=%h", rd_addr, rd_data);
      end
`endif
    end
  endtask

  task automatic test_reset_in_pend();
    for (int i = 0; i < 6; i++) do_write(3'(i), DW'($urandom));
    do_commit();
    tick();
    rst_n = 1'b0;
    model_reset();
    #2;
    checks++;
    if (dut_bank() !== model_bank() || swap_count !== 8'd0 || wr_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_pend got bank=%h cnt=%0d rdy=%b want bank=%h cnt=0 rdy=1",
               dut_bank(), swap_count, wr_ready, model_bank());
    end
    tick();
    rst_n = 1'b1;
    tick();
    do_commit();
    checks++;
    if (commit_nack !== 1'b1 || wr_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_dirty_cleared got nack=%b rdy=%b want 1/1", commit_nack, wr_ready);
    end
  endtask

  initial begin
    test_reset();
    test_directed_swap();
    test_incomplete();
    test_addr_err();
    test_timeout();
    test_same_cycle();
    test_random();
    test_reset_in_pend();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
